acc_wrap_monitor: RTL
=====================

# acc_wrap_monitor

Downstream companion to the 8-bit nibble accumulator. It watches the accumulator's `acc_reg` output every cycle and detects 8-bit wrap-around. It extends the count to a 16-bit running total and flags when that total reaches a programmable threshold. A one-shot capture FSM latches the total at the first threshold crossing after being armed, and holds it under a valid/ack handshake for the control side.

## Interface
Parameters:
- `THRESH`, default 16'd1000, 16-bit alert/capture threshold on the extended total.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `acc_reg`  in  8  accumulator output, driven from the accumulator's register.
- `clr`  in  1  synchronous clear of the wrap count and saturation flag.
- `arm`  in  1  single-cycle request to arm the capture FSM.
- `cap_ack`  in  1  consumer acknowledge of a held capture.
- `total`  out  16  registered extended total, {wrap_cnt, last sample}.
- `wrap_cnt`  out  8  number of wraps seen, saturating at 255.
- `sat`  out  1  sticky; set when a wrap occurs while wrap_cnt = 255.
- `alert`  out  1  registered, total >= THRESH.
- `cap_valid`  out  1  high while the FSM is in HOLD.
- `cap_value`  out  16  total latched at capture.
- `armed`  out  1  high while the FSM is in ARMED.

## Operation
- Sample register `prev[7:0]` loads `acc_reg` every cycle.
- Wrap detect, evaluated every cycle:
  - Condition is `acc_reg < prev`, unsigned.
  - The accumulator adds at most 15 per cycle, so a decrease means exactly one wrap.
- Wrap count:
  - On wrap with wrap_cnt < 255, wrap_cnt increments by 1.
  - On wrap with wrap_cnt = 255, wrap_cnt holds at 255 and `sat` is set.
  - `sat` clears only on reset or `clr`.
- Total:
  - `total` = {next wrap_cnt, acc_reg}, registered in the same edge as prev/wrap_cnt.
  - When `sat` = 1, `total` is forced to 16'hFFFF.
- Clear (`clr` = 1):
  - wrap_cnt <= 0, sat <= 0, prev <= acc_reg.
  - No wrap detect that cycle.
  - total <= {8'h00, acc_reg}.
- Alert: `alert` <= (total >= THRESH), compared against the registered `total`.
- Capture FSM, states IDLE, ARMED, HOLD:
  - IDLE: `arm` = 1 goes to ARMED.
  - ARMED: if the value being loaded into `total` this edge is >= THRESH, cap_value <= that value and go to HOLD. Otherwise stay.
  - ARMED with total already >= THRESH when entered: captures on the first ARMED edge.
  - HOLD: `cap_ack` = 1 goes to IDLE. If `arm` = 1 in the same cycle, go directly to ARMED.
  - HOLD: cap_value is stable for the whole of HOLD.
  - `arm` while ARMED or in HOLD without `cap_ack` is ignored.
  - `cap_ack` outside HOLD is ignored.
  - `clr` does not affect FSM state or cap_value.
- Reset, asserted at any time including mid-capture:
  - prev, wrap_cnt, total and cap_value are 0.
  - sat, alert and cap_valid are 0.
  - FSM is in IDLE.

## Timing
- Latency, acc_reg to total/wrap_cnt: 1 cycle.
- Latency, acc_reg to alert: 2 cycles.
- Latency, acc_reg to cap_valid: 1 cycle. The FSM compares the next total, not the registered one.
- `cap_valid` rises on the edge that captures and falls on the edge after `cap_ack` is sampled high.
- Minimum HOLD duration: 1 cycle.
- `armed` and `cap_valid` are decoded from the state register. They are glitch-free and never high together.
- Reset release: the first rising edge after `reset` goes high is the first update. The first sample is never a wrap, because prev = 0.

## Test plan
- Reset, then acc_reg = 8'd250 for 2 cycles, then 8'd5:
  - total = 16'h00FA, then 16'h0105.
  - wrap_cnt = 1, sat = 0.
- THRESH = 16'h0105, arm pulsed with acc_reg = 250, then acc_reg = 5:
  - cap_valid rises 1 cycle after acc_reg = 5, cap_value = 16'h0105.
  - alert rises 1 cycle later.
  - Hold cap_ack low 5 cycles: cap_value is unchanged. Pulse cap_ack: cap_valid is low next cycle.
- Drive 256 wraps:
  - wrap_cnt = 255 after wrap 255.
  - On wrap 256, sat = 1 and total = 16'hFFFF.
  - Pulse clr with acc_reg = 8'd7: wrap_cnt = 0, sat = 0, total = 16'h0007.
- In HOLD, assert arm and cap_ack together: FSM goes to ARMED, armed = 1, cap_valid = 0.
  - With total still >= THRESH, the next edge re-captures and cap_valid = 1.
- Assert reset mid-HOLD with wrap_cnt = 3: all outputs are 0 immediately (asynchronous), FSM is IDLE.
  - After release, acc_reg = 8'd10 gives total = 16'h000A with no wrap counted.

Source files
------------

// File: rtl/acc_wrap_monitor.sv
// Extends an 8-bit wrapping accumulator into a 16-bit running total, raises an
// alert at THRESH and captures the first crossing after arming under valid/ack.
module acc_wrap_monitor #(
    parameter logic [15:0] THRESH = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  acc_reg,
    input  logic        clr,
    input  logic        arm,
    input  logic        cap_ack,
    output logic [15:0] total,
    output logic [7:0]  wrap_cnt,
    output logic        sat,
    output logic        alert,
    output logic        cap_valid,
    output logic [15:0] cap_value,
    output logic        armed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic [7:0]  wrap_cnt_q, wrap_cnt_d;
    logic        sat_q, sat_d;
    logic [15:0] total_q, total_d;
    logic        alert_q, alert_d;
    logic [15:0] cap_value_q, cap_value_d;
    logic        wrap;

    // The accumulator adds at most 15 per cycle, so any decrease is one wrap.
    always_comb begin
        wrap       = 1'b0;
        prev_d     = acc_reg;
        wrap_cnt_d = wrap_cnt_q;
        sat_d      = sat_q;
        total_d    = total_q;
        alert_d    = (total_q >= THRESH);

        if (clr) begin
            wrap_cnt_d = 8'h00;
            sat_d      = 1'b0;
            total_d    = {8'h00, acc_reg};
        end else begin
            wrap = (acc_reg < prev_q);
            if (wrap) begin
                if (wrap_cnt_q == 8'hFF) begin
                    sat_d = 1'b1;
                end else begin
                    wrap_cnt_d = wrap_cnt_q + 8'd1;
                end
            end
            total_d = sat_d ? 16'hFFFF : {wrap_cnt_d, acc_reg};
        end
    end

    // Capture compares the total being loaded this edge, not the registered one.
    always_comb begin
        state_d     = state_q;
        cap_value_d = cap_value_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (total_d >= THRESH) begin
                    cap_value_d = total_d;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (cap_ack) begin
                    state_d = arm ? ARMED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= 8'h00;
            wrap_cnt_q  <= 8'h00;
            sat_q       <= 1'b0;
            total_q     <= 16'h0000;
            alert_q     <= 1'b0;
            cap_value_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            wrap_cnt_q  <= wrap_cnt_d;
            sat_q       <= sat_d;
            total_q     <= total_d;
            alert_q     <= alert_d;
            cap_value_q <= cap_value_d;
        end
    end

    assign total     = total_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign sat       = sat_q;
    assign alert     = alert_q;
    assign cap_value = cap_value_q;
    assign armed     = (state_q == ARMED);
    assign cap_valid = (state_q == HOLD);

endmodule
